// File: rtl/freq_gate_ctrl.sv
// Gated BCD frequency counter: counts sig_i rising edges over GATE_CYCLES clocks and latches the result.
// Optional macro FREQ_GATE_SYNC3_EN lengthens the input synchronizer from 2 to 3 flops.
module freq_gate_ctrl #(
   parameter int GATE_CYCLES = 50000000,
   parameter int DIGITS      = 5
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   run_i,
   input  logic                   sig_i,
   output logic [DIGITS-1:0][3:0] freq_bcd_o,
   output logic                   valid_o,
   output logic                   overflow_o,
   output logic                   busy_o
);

   localparam int TW = $clog2(GATE_CYCLES + 1);
`ifdef FREQ_GATE_SYNC3_EN
   localparam int SYNC_LEN = 3;
`else
   localparam int SYNC_LEN = 2;
`endif

   typedef enum logic [1:0] {IDLE, CLEAR, GATE, LATCH} state_t;

   state_t                  state;
   state_t                  state_nxt;
   logic [SYNC_LEN:0]       sync_q;
   logic                    rise;
   logic [TW-1:0]           timer;
   logic                    gate_last;
   logic [DIGITS-1:0][3:0]  cnt;
   logic [DIGITS-1:0][3:0]  cnt_inc;
   logic                    all_nines;
   logic                    carry;
   logic                    ovf;

   // Top bit is the extra registered copy used only for edge detection
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_LEN-1:0], sig_i};
      end
   end

   assign rise      = sync_q[SYNC_LEN-1] & ~sync_q[SYNC_LEN];
   assign gate_last = (timer == TW'(GATE_CYCLES - 1));
   assign busy_o    = (state != IDLE);

   always_comb begin
      cnt_inc = cnt;
      carry   = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (carry) begin
            if (cnt[i] == 4'd9) begin
               cnt_inc[i] = 4'd0;
            end else begin
               cnt_inc[i] = cnt[i] + 4'd1;
               carry      = 1'b0;
            end
         end
      end
      // A carry out of the top digit means every digit was 9
      all_nines = carry;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (run_i) state_nxt = CLEAR;
         CLEAR:   state_nxt = GATE;
         GATE:    if (gate_last) state_nxt = LATCH;
         LATCH:   state_nxt = run_i ? CLEAR : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state      <= IDLE;
         timer      <= '0;
         cnt        <= '0;
         ovf        <= 1'b0;
         freq_bcd_o <= '0;
         overflow_o <= 1'b0;
         valid_o    <= 1'b0;
      end else begin
         state   <= state_nxt;
         valid_o <= 1'b0;
         case (state)
            CLEAR: begin
               cnt   <= '0;
               ovf   <= 1'b0;
               timer <= '0;
            end
            GATE: begin
               timer <= timer + TW'(1);
               if (rise) begin
                  if (all_nines) ovf <= 1'b1;
                  else           cnt <= cnt_inc;
               end
            end
            LATCH: begin
               freq_bcd_o <= cnt;
               overflow_o <= ovf;
               valid_o    <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
